psum_accum_relu: RTL and testbench
==================================

Name: psum_accum_relu

Overview:
- Output-stage consumer directly downstream of the output FIFO (column-parallel partial sums from the MAC array).
- Pops one col-wide psum vector per output pixel, accumulates across cfg_npass kernel passes into an internal per-pixel buffer, then drains the results with optional ReLU through a valid/ready port toward the output SRAM writer.

Parameters:
- col, 8, number of array columns (lanes per vector).
- psum_bw, 16, signed psum and accumulator width per lane.
- DEPTH, 16, number of pixel entries in the accumulation buffer.
- AW, 4, log2(DEPTH).
- RD_GAP, 2, idle cycles after each pop so the FIFO head and valid flag settle.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle job start; ignored while busy.
- cfg_npix  in  AW+1  pixels per pass, 1..DEPTH; 0 treated as 1, values above DEPTH treated as DEPTH.
- cfg_npass  in  4  passes to accumulate, 1..15; 0 treated as 1.
- relu_en  in  1  sampled at start; 1 clamps negative results to 0 on drain.
- fifo_valid  in  1  FIFO holds a complete vector (all columns non-empty).
- fifo_data  in  col*psum_bw  show-ahead head vector, lane i at bits [psum_bw*(i+1)-1 : psum_bw*i].
- fifo_rd  out  1  pop request to the FIFO.
- out_data  out  col*psum_bw  drained result vector, same lane packing.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset: state IDLE; fifo_rd, out_valid, busy and done are 0; out_data is 0; pix and pass counters are 0. Accumulation buffer contents are not cleared, because pass 0 overwrites them.
- Reset mid-job: abandons the job immediately, with no further pops or outputs.
- IDLE:
  - On start, latch the clamped cfg_npix, cfg_npass and relu_en.
  - Clear pix and pass, then go to READ.
- READ:
  - fifo_rd = fifo_valid (combinational from state).
  - When fifo_valid=1 in the same cycle, capture fifo_data. On pass 0, acc[pix] <= data. Otherwise acc[pix] <= sat_add(acc[pix], data) per lane.
  - Then go to GAP.
  - If pix == npix-1, set pix to 0 and increment pass; otherwise increment pix.
  - When fifo_valid=0, hold state and issue no pop.
- GAP: wait exactly RD_GAP cycles with fifo_rd=0. Then go to DRAIN if pass == npass, else back to READ. Pop spacing is therefore RD_GAP+1 cycles.
- DRAIN:
  - out_valid=1; out_data = f(acc[pix]) computed combinationally, where f is a per-lane ReLU when relu_en is set and identity otherwise.
  - On out_valid & out_ready, advance pix. Accepting the last entry (pix == npix-1) goes to DONE.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. A start arriving in DONE is ignored.
- Arithmetic:
  - Signed two's-complement, lane-independent.
  - sat_add saturates to +2^(psum_bw-1)-1 and -2^(psum_bw-1); it never wraps.
  - ReLU maps any value with the MSB set to 0.
- fifo_rd is never asserted outside READ and never while fifo_valid=0.
- Total pops per job = npix*npass. Total outputs per job = npix.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, READ, GAP, DRAIN, DONE;
  - the psum_bw default;
  - saturation limit constants.
- One natural sub-module, psum_lane_alu: a single-lane saturating add (with an overwrite select for pass 0) plus the ReLU output mux, instantiated col times by generate.
- Buffer storage, counters and FSM stay in the top module.

Test Plan:
- Single pass: npix=4, npass=1, relu_en=0; FIFO supplies vectors with every lane = 1,2,3,4 -> exactly 4 pops spaced 3 cycles apart; drain outputs 1,2,3,4; one done pulse.
- Accumulation: npix=2, npass=9; every pop has all lanes = 5 -> 18 pops; both outputs have all lanes = 45.
- Saturation and ReLU: npix=1, npass=3, relu_en=1; lane0 gets +20000 three times and lane1 gets -20000 three times -> lane0 = 32767, lane1 = 0. Same stimulus with relu_en=0 gives lane1 = -32768.
- Stalls:
  - Toggle fifo_valid low for 5 cycles mid-pass -> no fifo_rd while it is low.
  - Hold out_ready low for 4 cycles during drain -> out_data stable, no entry skipped, outputs in pixel order.
- Start ignored while busy: pulse start during READ with different cfg -> job completes with the original cfg. Clamping: cfg_npix=0 produces 1 output; cfg_npix=31 produces 16.
- Reset mid-DRAIN after 2 of 4 outputs -> the next cycle has out_valid=0, busy=0 and fifo_rd=0. A new job (npix=2, npass=1) then runs correctly, with pass-0 overwrite proven by an absence of stale sums.

Source files
------------

// File: rtl/psum_accum_relu_pkg.sv
// Shared types and constants for the partial-sum accumulate / ReLU output stage.
// Saturation limits are width-generic constant functions so any lane width can use them.
package psum_accum_relu_pkg;

  localparam int PSUM_BW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [31:0] sat_hi(input int bw);
    return (32'd1 << (bw - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_lo(input int bw);
    return 32'd1 << (bw - 1);
  endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// One lane of the accumulator datapath: saturating add (or overwrite on the first pass)
// and the ReLU mux applied to the stored value on drain.
module psum_lane_alu
  import psum_accum_relu_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic [psum_bw-1:0] acc_i,
  input  logic [psum_bw-1:0] data_i,
  input  logic               overwrite_i,
  input  logic               relu_en_i,
  output logic [psum_bw-1:0] sum_o,
  output logic [psum_bw-1:0] relu_o
);

  localparam logic [psum_bw-1:0] LIM_MAX = psum_bw'(sat_hi(psum_bw));
  localparam logic [psum_bw-1:0] LIM_MIN = psum_bw'(sat_lo(psum_bw));

  logic [psum_bw:0] wide;

  always_comb begin
    wide = {acc_i[psum_bw-1], acc_i} + {data_i[psum_bw-1], data_i};
    // The two top bits of the sign-extended sum disagree only on overflow.
    if (overwrite_i) begin
      sum_o = data_i;
    end else if (wide[psum_bw] != wide[psum_bw-1]) begin
      sum_o = wide[psum_bw] ? LIM_MIN : LIM_MAX;
    end else begin
      sum_o = wide[psum_bw-1:0];
    end
    relu_o = (relu_en_i && acc_i[psum_bw-1]) ? '0 : acc_i;
  end

endmodule

// File: rtl/psum_accum_relu.sv
// Pops column psum vectors from the output FIFO, accumulates them per pixel across
// kernel passes, then drains the sums (optionally ReLU-clamped) over valid/ready.
//
// state    | meaning
// ST_IDLE  | waiting for start; config latched on start
// ST_READ  | pop one vector when the FIFO has one, write acc[pix]
// ST_GAP   | RD_GAP idle cycles so the FIFO head/valid settle after a pop
// ST_DRAIN | present f(acc[pix]) until accepted, step pix
// ST_DONE  | one-cycle completion pulse
module psum_accum_relu
  import psum_accum_relu_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = PSUM_BW,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int RD_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW:0]            cfg_npix,
  input  logic [3:0]             cfg_npass,
  input  logic                   relu_en,
  input  logic                   fifo_valid,
  input  logic [col*psum_bw-1:0] fifo_data,
  output logic                   fifo_rd,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int GW = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     pix_q, pix_d;
  logic [3:0]        pass_q, pass_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [AW:0]       npix_q, npix_d;
  logic [3:0]        npass_q, npass_d;
  logic              relu_q, relu_d;

  logic [col*psum_bw-1:0] acc_q [DEPTH];
  logic [col*psum_bw-1:0] acc_rd;
  logic [col*psum_bw-1:0] sum_vec;
  logic [col*psum_bw-1:0] relu_vec;
  logic                   acc_we;
  logic                   last_pix;
  logic [AW:0]            npix_clamp;

  assign acc_rd   = acc_q[pix_q];
  assign last_pix = ({1'b0, pix_q} == (npix_q - 1'b1));

  always_comb begin
    if (cfg_npix == '0) begin
      npix_clamp = (AW+1)'(1);
    end else if (cfg_npix > (AW+1)'(DEPTH)) begin
      npix_clamp = (AW+1)'(DEPTH);
    end else begin
      npix_clamp = cfg_npix;
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_alu #(.psum_bw(psum_bw)) u_lane (
      .acc_i      (acc_rd[i*psum_bw +: psum_bw]),
      .data_i     (fifo_data[i*psum_bw +: psum_bw]),
      .overwrite_i(pass_q == 4'd0),
      .relu_en_i  (relu_q),
      .sum_o      (sum_vec[i*psum_bw +: psum_bw]),
      .relu_o     (relu_vec[i*psum_bw +: psum_bw])
    );
  end

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    pass_d    = pass_q;
    gap_d     = gap_q;
    npix_d    = npix_q;
    npass_d   = npass_q;
    relu_d    = relu_q;
    fifo_rd   = 1'b0;
    out_valid = 1'b0;
    acc_we    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          npix_d  = npix_clamp;
          npass_d = (cfg_npass == 4'd0) ? 4'd1 : cfg_npass;
          relu_d  = relu_en;
          pix_d   = '0;
          pass_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        fifo_rd = fifo_valid;
        if (fifo_valid) begin
          acc_we  = 1'b1;
          gap_d   = GW'(RD_GAP - 1);
          state_d = ST_GAP;
          if (last_pix) begin
            pix_d  = '0;
            pass_d = pass_q + 4'd1;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = (pass_q == npass_q) ? ST_DRAIN : ST_READ;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_pix) begin
            pix_d   = '0;
            state_d = ST_DONE;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drained data comes straight from the buffer, so it is stable while stalled.
  assign out_data = (state_q == ST_DRAIN) ? relu_vec : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
      npix_q  <= (AW+1)'(1);
      npass_q <= 4'd1;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      pass_q  <= pass_d;
      gap_q   <= gap_d;
      npix_q  <= npix_d;
      npass_q <= npass_d;
      relu_q  <= relu_d;
    end
  end

  // No reset on the buffer: pass 0 always overwrites before any entry is read.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_q[pix_q] <= sum_vec;
    end
  end

endmodule

// File: tb/tb_psum_accum_relu.sv
// Directed bench for psum_accum_relu: table of single-value jobs plus hand-written
// sequences for saturation, stalls, start-while-busy and reset mid-drain.
module tb_psum_accum_relu;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int W   = COL * BW;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   cfg_npix = '0;
  logic [3:0]    cfg_npass = '0;
  logic          relu_en = 1'b0;
  logic          fifo_valid = 1'b0;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_rd;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int dones = 0;
  int cyc = 0;
  int stab_checks = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] outq[$];
  int           pop_cyc[$];
  bit           hold = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  psum_accum_relu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_npix  (cfg_npix),
    .cfg_npass (cfg_npass),
    .relu_en   (relu_en),
    .fifo_valid(fifo_valid),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // FIFO model and monitors: inputs settle at negedge+1, outputs sampled at negedge+2.
  always begin
    @(negedge clk);
    #1;
    fifo_valid = (fq.size() > 0) && !hold;
    if (fq.size() > 0) fifo_data = fq[0];
    else fifo_data = '0;
    #1;
    cyc++;
    if (fifo_rd) begin
      checks++;
      if (!fifo_valid) begin
        errors++;
        $display("FAIL pop_without_valid: fifo_rd=1 fifo_valid=%0b at cycle %0d", fifo_valid, cyc);
      end
      if (fq.size() > 0) void'(fq.pop_front());
      pops++;
      pop_cyc.push_back(cyc);
    end
    if (stall_prev && out_valid) begin
      checks++;
      stab_checks++;
      if (out_data !== stall_data) begin
        errors++;
        $display("FAIL out_stable: got %h required %h", out_data, stall_data);
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (out_valid && out_ready) outq.push_back(out_data);
    if (done) dones++;
  end

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    logic [BW-1:0] l;
    l = v[BW-1:0];
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = l;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    outq.delete();
    pop_cyc.delete();
    pops = 0;
  endtask

  task automatic start_job(input int np, input int ns, input bit r);
    @(negedge clk);
    cfg_npix  = np[AW:0];
    cfg_npass = ns[3:0];
    relu_en   = r;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    relu_en = ~r;
  endtask

  task automatic wait_done(input string nm);
    int d0 = dones;
    int n = 0;
    while (dones == d0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (dones == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", nm, n);
    end
    repeat (2) @(negedge clk);
    #3;
    chk_int({nm, "_done_pulses"}, dones - d0, 1);
    chk_int({nm, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic wait_outs(input int k);
    int n = 0;
    while (outq.size() < k && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (outq.size() < k) begin
      checks++;
      errors++;
      $display("FAIL wait_outs_timeout: got %0d outputs required %0d", outq.size(), k);
    end
  endtask

  typedef struct {
    int npix_cfg;
    int npass_cfg;
    bit relu;
    int base;
    int step;
    int exp_n;
    int exp_pops;
    int exp_first;
    int exp_last;
  } tv_t;

  tv_t tv[6];

  initial begin
    logic [W-1:0] sv;
    int bad;
    int p0;
    int s0;

    tv[0] = '{4, 1, 1'b0, 1, 1, 4, 4, 1, 4};
    tv[1] = '{2, 9, 1'b0, 5, 0, 2, 18, 45, 45};
    tv[2] = '{0, 1, 1'b0, 7, 0, 1, 1, 7, 7};
    tv[3] = '{31, 1, 1'b1, -8, 1, 16, 16, 0, 7};
    tv[4] = '{3, 0, 1'b0, 100, -50, 3, 3, 100, 0};
    tv[5] = '{3, 2, 1'b0, -10, 10, 3, 6, -20, 20};

    repeat (3) @(negedge clk);
    #3;
    chk_int("rst_fifo_rd", int'(fifo_rd), 0);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      clear_logs();
      for (int s = 0; s < tv[t].exp_pops / tv[t].exp_n; s++)
        for (int p = 0; p < tv[t].exp_n; p++)
          fq.push_back(rep(tv[t].base + p * tv[t].step));
      start_job(tv[t].npix_cfg, tv[t].npass_cfg, tv[t].relu);
      wait_done($sformatf("tv%0d", t));
      chk_int($sformatf("tv%0d_pops", t), pops, tv[t].exp_pops);
      chk_int($sformatf("tv%0d_nout", t), outq.size(), tv[t].exp_n);
      if (outq.size() > 0) begin
        chk($sformatf("tv%0d_first", t), outq[0], rep(tv[t].exp_first));
        chk($sformatf("tv%0d_last", t), outq[outq.size()-1], rep(tv[t].exp_last));
      end
      bad = 0;
      for (int i = 1; i < pop_cyc.size(); i++)
        if (pop_cyc[i] - pop_cyc[i-1] != 3) bad++;
      chk_int($sformatf("tv%0d_pop_spacing", t), bad, 0);
      fq.delete();
    end

    // Saturation: lane0 +20000 x3, lane1 -20000 x3.
    for (int r = 1; r >= 0; r--) begin
      clear_logs();
      sv = '0;
      sv[15:0]  = 16'h4E20;
      sv[31:16] = 16'hB1E0;
      repeat (3) fq.push_back(sv);
      start_job(1, 3, r[0]);
      wait_done($sformatf("sat_relu%0d", r));
      sv = '0;
      sv[15:0]  = 16'h7FFF;
      sv[31:16] = (r == 1) ? 16'h0000 : 16'h8000;
      chk_int($sformatf("sat_relu%0d_nout", r), outq.size(), 1);
      if (outq.size() > 0) chk($sformatf("sat_relu%0d_data", r), outq[0], sv);
    end

    // FIFO empty for 5 cycles mid-pass: no pops while fifo_valid is low.
    clear_logs();
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 4; p++) fq.push_back(rep(p + 1));
    start_job(4, 2, 1'b0);
    begin
      int n = 0;
      while (pops < 3 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    hold = 1'b1;
    p0 = pops;
    repeat (5) @(negedge clk);
    chk_int("hold_no_pops", pops, p0);
    hold = 1'b0;
    wait_done("hold");
    chk_int("hold_pops", pops, 8);
    chk_int("hold_nout", outq.size(), 4);
    for (int i = 0; i < outq.size(); i++)
      chk($sformatf("hold_out%0d", i), outq[i], rep(2 * (i + 1)));

    // out_ready low for 4 cycles during drain.
    clear_logs();
    for (int p = 0; p < 4; p++) fq.push_back(rep(10 * (p + 1)));
    start_job(4, 1, 1'b0);
    wait_outs(1);
    s0 = stab_checks;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    wait_done("bp");
    chk_int("bp_stall_seen", int'(stab_checks - s0 >= 4), 1);
    chk_int("bp_nout", outq.size(), 4);
    for (int i = 0; i < outq.size(); i++)
      chk($sformatf("bp_out%0d", i), outq[i], rep(10 * (i + 1)));

    // Start with different cfg while waiting in READ is ignored.
    clear_logs();
    start_job(2, 1, 1'b0);
    repeat (4) @(negedge clk);
    start_job(5, 3, 1'b1);
    fq.push_back(rep(3));
    fq.push_back(rep(-4));
    wait_done("busy_start");
    chk_int("busy_start_pops", pops, 2);
    chk_int("busy_start_nout", outq.size(), 2);
    if (outq.size() == 2) begin
      chk("busy_start_out0", outq[0], rep(3));
      chk("busy_start_out1", outq[1], rep(-4));
    end

    // Reset after 2 of 4 drained outputs, then a fresh job must overwrite old sums.
    clear_logs();
    for (int p = 0; p < 4; p++) fq.push_back(rep(p + 1));
    start_job(4, 1, 1'b0);
    wait_outs(2);
    reset = 1'b1;
    @(negedge clk);
    #3;
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk_int("mid_rst_busy", int'(busy), 0);
    chk_int("mid_rst_fifo_rd", int'(fifo_rd), 0);
    reset = 1'b0;
    fq.delete();
    clear_logs();
    fq.push_back(rep(9));
    fq.push_back(rep(-3));
    start_job(2, 1, 1'b0);
    wait_done("post_rst");
    chk_int("post_rst_nout", outq.size(), 2);
    if (outq.size() == 2) begin
      chk("post_rst_out0", outq[0], rep(9));
      chk("post_rst_out1", outq[1], rep(-3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
